// File: rtl/lock_pkg.sv
// Shared types and defaults for the keypad combination-lock supervisor.
package lock_pkg;

  typedef enum logic [1:0] {
    StLocked   = 2'd0,
    StUnlocked = 2'd1,
    StProgram  = 2'd2,
    StLockout  = 2'd3
  } lock_state_e;

  localparam int unsigned DefDigitW  = 3;
  localparam int unsigned DefCodeLen = 3;
  localparam logic [DefDigitW*DefCodeLen-1:0] DefCode = {3'b101, 3'b011, 3'b101};

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_supervisor_if.sv
// Keypad-side and actuator-side signals of the lock supervisor.
interface lock_supervisor_if #(
  parameter int unsigned DIGIT_W = 3,
  parameter int unsigned FAIL_W  = 2
);
  logic [DIGIT_W-1:0] X;
  logic               e;
  logic               lock_cmd;
  logic               prog;
  logic               L;
  logic               alarm;
  logic               prog_done;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [1:0]         state;

  modport master (
    output X, e, lock_cmd, prog,
    input  L, alarm, prog_done, fail_cnt, state
  );

  modport slave (
    input  X, e, lock_cmd, prog,
    output L, alarm, prog_done, fail_cnt, state
  );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; shared by all timed states.
module lock_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Combination-lock sequencer: digit entry/compare, unlock with auto-relock, failure lockout
// with alarm, and code change while open.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int unsigned DIGIT_W      = DefDigitW,
  parameter int unsigned CODE_LEN     = DefCodeLen,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = DefCode,
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned LOCKOUT_CYC  = 1024,
  parameter int unsigned RELOCK_CYC   = 256,
  parameter int unsigned ENTRY_TO_CYC = 64
) (
  input logic               clk,
  input logic               r,
  lock_supervisor_if.slave  bus
);

  localparam int unsigned CODE_W  = DIGIT_W * CODE_LEN;
  localparam int unsigned IDX_W   = $clog2(CODE_LEN);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TIMER_W = $clog2(max3(LOCKOUT_CYC, RELOCK_CYC, ENTRY_TO_CYC) + 1);

  localparam logic [IDX_W-1:0]   LastIdx   = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0]  MaxFails  = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] LockoutT  = TIMER_W'(LOCKOUT_CYC);
  localparam logic [TIMER_W-1:0] RelockT   = TIMER_W'(RELOCK_CYC);
  localparam logic [TIMER_W-1:0] EntryT    = TIMER_W'(ENTRY_TO_CYC);

  lock_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                mismatch_q, mismatch_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic                l_q, alarm_q, prog_done_q, prog_done_d;

  logic                t_load;
  logic [TIMER_W-1:0]  t_val;
  logic [TIMER_W-1:0]  t_cnt;
  logic                t_zero;
  logic                expire;
  logic                digit_ok;

  lock_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (r),
    .load     (t_load),
    .load_val (t_val),
    .cnt      (t_cnt),
    .zero     (t_zero)
  );

  // Expire on the edge where the counter reaches zero, so a load of N gives exactly N cycles.
  assign expire = t_zero | (t_cnt == TIMER_W'(1));

  // Digit 0 of a code lives in the MSBs.
  function automatic int unsigned digit_lsb(input logic [IDX_W-1:0] idx);
    return (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
  endfunction

  assign digit_ok = (bus.X == code_q[digit_lsb(idx_q) +: DIGIT_W]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mismatch_d  = mismatch_q;
    fail_d      = fail_q;
    code_d      = code_q;
    shadow_d    = shadow_q;
    prog_done_d = 1'b0;
    t_load      = 1'b0;
    t_val       = '0;

    unique case (state_q)
      StLocked: begin
        if (bus.e) begin
          t_load = 1'b1;
          t_val  = EntryT;
          if (idx_q == LastIdx) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!mismatch_q && digit_ok) begin
              state_d = StUnlocked;
              fail_d  = '0;
              t_val   = RelockT;
            end else begin
              if (fail_q != MaxFails) begin
                fail_d = fail_q + FAIL_W'(1);
              end
              if (fail_d == MaxFails) begin
                state_d = StLockout;
                t_val   = LockoutT;
              end
            end
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            mismatch_d = mismatch_q | ~digit_ok;
          end
        end else if (idx_q != '0 && expire) begin
          // Abandoned partial entry: forgotten silently, not counted as a failure.
          idx_d      = '0;
          mismatch_d = 1'b0;
        end
      end

      StUnlocked: begin
        if (bus.lock_cmd || expire) begin
          state_d = StLocked;
          idx_d   = '0;
        end else if (bus.prog) begin
          state_d = StProgram;
          idx_d   = '0;
          t_load  = 1'b1;
          t_val   = EntryT;
        end
      end

      StProgram: begin
        if (bus.lock_cmd) begin
          state_d = StLocked;
          idx_d   = '0;
        end else if (bus.e) begin
          shadow_d[digit_lsb(idx_q) +: DIGIT_W] = bus.X;
          t_load = 1'b1;
          t_val  = EntryT;
          if (idx_q == LastIdx) begin
            code_d      = shadow_d;
            prog_done_d = 1'b1;
            state_d     = StUnlocked;
            idx_d       = '0;
            t_val       = RelockT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (expire) begin
          state_d = StUnlocked;
          idx_d   = '0;
          t_load  = 1'b1;
          t_val   = RelockT;
        end
      end

      StLockout: begin
        if (expire) begin
          state_d    = StLocked;
          fail_d     = '0;
          idx_d      = '0;
          mismatch_d = 1'b0;
        end
      end

      default: state_d = StLocked;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= StLocked;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      fail_q      <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= DEFAULT_CODE;
      l_q         <= 1'b0;
      alarm_q     <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mismatch_q  <= mismatch_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      l_q         <= (state_d == StUnlocked) || (state_d == StProgram);
      alarm_q     <= (state_d == StLockout);
      prog_done_q <= prog_done_d;
    end
  end

  assign bus.L         = l_q;
  assign bus.alarm     = alarm_q;
  assign bus.prog_done = prog_done_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor with shortened timers (lockout 20, relock 10, entry 5).
module tb_lock_supervisor;

  logic clk = 1'b0;
  logic r   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lock_supervisor_if #(.DIGIT_W(3), .FAIL_W(2)) lif ();

  lock_supervisor #(
    .LOCKOUT_CYC  (20),
    .RELOCK_CYC   (10),
    .ENTRY_TO_CYC (5)
  ) dut (
    .clk (clk),
    .r   (r),
    .bus (lif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic digit(input logic [2:0] d);
    lif.X = d;
    lif.e = 1'b1;
    tick();
    lif.e = 1'b0;
  endtask

  task automatic code3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    digit(a);
    digit(b);
    digit(c);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    lif.X = '0;
    lif.e = 1'b0;
    lif.lock_cmd = 1'b0;
    lif.prog = 1'b0;
    #2;
    chk("rst_L", 32'(lif.L), 0);
    chk("rst_alarm", 32'(lif.alarm), 0);
    chk("rst_prog_done", 32'(lif.prog_done), 0);
    chk("rst_fail", 32'(lif.fail_cnt), 0);
    chk("rst_state", 32'(lif.state), 0);
    idle(2);
    r = 1'b0;
    tick();

    // Correct code unlocks one cycle after the third digit.
    digit(3'd5);
    digit(3'd3);
    chk("mid_entry_L", 32'(lif.L), 0);
    digit(3'd5);
    chk("unlock_L", 32'(lif.L), 1);
    chk("unlock_state", 32'(lif.state), 1);
    chk("unlock_fail", 32'(lif.fail_cnt), 0);

    // Auto-relock exactly 10 cycles after unlock.
    idle(9);
    chk("relock_before_L", 32'(lif.L), 1);
    idle(1);
    chk("relock_L", 32'(lif.L), 0);
    chk("relock_state", 32'(lif.state), 0);

    // Explicit relock before the timer runs out.
    code3(3'd5, 3'd3, 3'd5);
    idle(3);
    lif.lock_cmd = 1'b1;
    tick();
    lif.lock_cmd = 1'b0;
    chk("lock_cmd_L", 32'(lif.L), 0);
    chk("lock_cmd_state", 32'(lif.state), 0);

    // Three wrong entries: lockout with alarm.
    code3(3'd5, 3'd3, 3'd4);
    chk("fail1", 32'(lif.fail_cnt), 1);
    chk("fail1_L", 32'(lif.L), 0);
    code3(3'd5, 3'd3, 3'd4);
    chk("fail2", 32'(lif.fail_cnt), 2);
    chk("fail2_alarm", 32'(lif.alarm), 0);
    code3(3'd5, 3'd3, 3'd4);
    chk("lockout_alarm", 32'(lif.alarm), 1);
    chk("lockout_state", 32'(lif.state), 3);
    chk("lockout_fail", 32'(lif.fail_cnt), 3);
    code3(3'd5, 3'd3, 3'd5);
    chk("lockout_ignores_e_L", 32'(lif.L), 0);
    chk("lockout_ignores_e_alarm", 32'(lif.alarm), 1);
    idle(16);
    chk("lockout_end_minus1", 32'(lif.alarm), 1);
    idle(1);
    chk("lockout_exit_alarm", 32'(lif.alarm), 0);
    chk("lockout_exit_fail", 32'(lif.fail_cnt), 0);
    chk("lockout_exit_state", 32'(lif.state), 0);

    // Partial entry abandoned after idle gap; fresh entry then succeeds.
    digit(3'd5);
    digit(3'd3);
    idle(6);
    code3(3'd5, 3'd3, 3'd5);
    chk("abandon_unlock_L", 32'(lif.L), 1);
    chk("abandon_fail", 32'(lif.fail_cnt), 0);

    // Program new code 1,2,7.
    lif.prog = 1'b1;
    tick();
    lif.prog = 1'b0;
    chk("prog_state", 32'(lif.state), 2);
    chk("prog_L", 32'(lif.L), 1);
    digit(3'd1);
    digit(3'd2);
    chk("prog_no_done_yet", 32'(lif.prog_done), 0);
    digit(3'd7);
    chk("prog_done_pulse", 32'(lif.prog_done), 1);
    chk("prog_back_unlocked", 32'(lif.state), 1);
    tick();
    chk("prog_done_cleared", 32'(lif.prog_done), 0);
    lif.lock_cmd = 1'b1;
    tick();
    lif.lock_cmd = 1'b0;
    chk("prog_relock_L", 32'(lif.L), 0);
    code3(3'd5, 3'd3, 3'd5);
    chk("old_code_L", 32'(lif.L), 0);
    chk("old_code_fail", 32'(lif.fail_cnt), 1);
    code3(3'd1, 3'd2, 3'd7);
    chk("new_code_L", 32'(lif.L), 1);
    chk("new_code_fail", 32'(lif.fail_cnt), 0);

    // lock_cmd with the final program digit: abort wins, code unchanged.
    lif.prog = 1'b1;
    tick();
    lif.prog = 1'b0;
    digit(3'd4);
    digit(3'd4);
    lif.X = 3'd4;
    lif.e = 1'b1;
    lif.lock_cmd = 1'b1;
    tick();
    lif.e = 1'b0;
    lif.lock_cmd = 1'b0;
    chk("abort_state", 32'(lif.state), 0);
    chk("abort_no_done", 32'(lif.prog_done), 0);
    code3(3'd1, 3'd2, 3'd7);
    chk("abort_code_kept", 32'(lif.L), 1);

    // Async reset mid-program restores the default code.
    lif.prog = 1'b1;
    tick();
    lif.prog = 1'b0;
    digit(3'd6);
    digit(3'd6);
    #2;
    r = 1'b1;
    #1;
    chk("async_rst_L", 32'(lif.L), 0);
    chk("async_rst_state", 32'(lif.state), 0);
    tick();
    r = 1'b0;
    tick();
    code3(3'd5, 3'd3, 3'd5);
    chk("rst_restores_code", 32'(lif.L), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
